fsm_rdm_lanes: RTL and testbench
================================

Name: fsm_rdm_lanes

Overview:
- Parametrised rate-dematching read engine. Supersedes the fixed 16x6-bit FSM_RDM.
- Fetches E LLRs from the input buffer, LANES per word, and maps them onto the circular buffer (size Ncb, starting position K0).
- Emits lane-masked beats (circular address, data, accumulate flag) to the HARQ combine stage.
- New versus FSM_RDM: generic lane count and LLR width, K0 start offset, split beats at the Ncb wrap, repetition (accumulate) marking, downstream back-pressure and config error detection.

Parameters:
- LANES, 16, LLRs per input word (power of 2, ≥2).
- LLR_W, 6, bits per LLR.
- E_W, 14, width of the E size.
- ADDR_W, 16, width of the Ncb, K0, circular address and input offset address.

Ports:
- i_core_clk  in  1  single clock, all logic on rising edge.
- i_rx_rst  in  1  synchronous reset, active-high.
- i_Combine_process_request  in  1  start; sampled only in IDLE.
- i_Current_Combine_E01_Size  in  E_W  E, number of LLRs to process.
- i_Current_Combine_Ncb_Size  in  ADDR_W  Ncb, circular buffer size.
- i_Current_K0  in  ADDR_W  circular start position.
- o_Input_Buffer_Offset_Address  out  ADDR_W  input word address.
- o_Input_Buffer_RDM_Data_Enable  out  1  read strobe; data is returned 1 cycle later.
- i_Input_Buffer_RDM_Data  in  LANES*LLR_W  read data; lane i is at bits [i*LLR_W +: LLR_W].
- i_RDM_Data_Request  in  1  downstream ready.
- o_Rdm_Valid  out  1  beat valid.
- o_Rdm_Addr  out  ADDR_W  circular position of output lane 0.
- o_Rdm_Lane_Mask  out  LANES  valid lanes, contiguous from lane 0.
- o_Rdm_Data  out  LANES*LLR_W  LLRs; lane i maps to position o_Rdm_Addr+i. Masked-off lanes are 0.
- o_Rdm_Accumulate  out  1  beat targets positions already written in this job (pass>0).
- o_Rdm_Busy  out  1  high in every state except IDLE.
- o_Rdm_Done  out  1  one-cycle pulse at end of job.
- o_Cfg_Error  out  1  sticky config error; cleared on the next accepted start.

Behaviour:
- Reset (i_rx_rst=1 at a clock edge):
  - State goes to IDLE.
  - All outputs and internal counters go to 0.
  - Reset mid-job aborts the job; no Done pulse is produced.
- IDLE: when i_Combine_process_request=1:
  - Latch E, Ncb and K0. Set word=0, pos=K0, pass=0, remaining=E. Clear o_Cfg_Error.
  - If E==0, go to DONE.
  - If Ncb<LANES or K0≥Ncb, set o_Cfg_Error=1 and go to DONE.
  - Otherwise go to FETCH.
- FETCH (1 cycle):
  - Drive o_Input_Buffer_RDM_Data_Enable=1 and o_Input_Buffer_Offset_Address=word.
  - Go to LATCH. Enable is 0 in all other states.
- LATCH (1 cycle): register i_Input_Buffer_RDM_Data, compute n=min(LANES, remaining) and s=Ncb-pos, then go to EMIT.
- EMIT: present o_Rdm_Valid=1, o_Rdm_Addr=pos, o_Rdm_Accumulate=(pass≠0).
  - If n≤s: mask has the low n lanes set.
  - If n>s: mask has the low s lanes set (first half of a split).
  - Beat completes on a cycle with o_Rdm_Valid & i_RDM_Data_Request.
  - While ready=0, every beat output holds stable.
  - On completion without a split: pos+=n (if pos==Ncb then pos=0 and pass+=1), remaining-=n, word+=1. Go to DONE if remaining==0, else FETCH.
  - On completion with a split: go to EMIT_WRAP.
- EMIT_WRAP: latched lanes s..n-1 are shifted down to lanes 0..n-s-1.
  - Outputs: o_Rdm_Addr=0, mask has the low n-s lanes set, o_Rdm_Accumulate=1.
  - On completion: pos=n-s, pass+=1, remaining-=n, word+=1. Go to FETCH or DONE as in EMIT.
- DONE (1 cycle): o_Rdm_Done=1, then go to IDLE.
- Rules:
  - Because Ncb≥LANES, a word wraps at most once.
  - pass saturates at all-ones.
  - o_Rdm_Valid=0 outside EMIT and EMIT_WRAP.
  - A start asserted outside IDLE is ignored.
- Throughput: 3 cycles per word without a split, 4 with a split, assuming ready=1.

Test Plan:
- LANES=16. E=129, Ncb=110, K0=0, ready=1:
  - 9 reads at addresses 0..8.
  - 10 beats: addr 0,16,..,80 with full mask; addr 96 mask 0x3FFF; addr 0 mask 0x0003 acc=1; addr 2 mask 0xFFFF acc=1; addr 18 mask 0x0001 acc=1.
  - Lane data matches the buffer contents; Done pulses once.
- E=32, Ncb=110, K0=100:
  - addr 100 mask 0x03FF acc=0; addr 0 mask 0x003F acc=1 with lanes 10..15 shifted to 0..5; addr 6 mask 0xFFFF acc=1.
- Back-pressure: same job as the first scenario with ready toggled 1-0-0-1 randomly.
  - Beat sequence is identical.
  - Outputs hold stable while ready=0.
  - No read is issued while a beat is pending.
- Config errors, each case: o_Cfg_Error=1, o_Rdm_Done pulse, zero reads, zero beats.
  - Ncb=8.
  - K0=110 with Ncb=110.
- E=0: Done pulses 2 cycles after the start; no reads; o_Cfg_Error=0.
- Reset asserted while in EMIT of beat 3:
  - Next cycle: all outputs 0, o_Rdm_Busy=0, no Done pulse.
  - A subsequent start reruns the full first scenario correctly.

Source files
------------

// File: rtl/fsm_rdm_lanes.sv
// rtl/fsm_rdm_lanes.sv - lane-parallel rate-dematching read engine onto a circular buffer
module fsm_rdm_lanes #(
  parameter int LANES  = 16,
  parameter int LLR_W  = 6,
  parameter int E_W    = 14,
  parameter int ADDR_W = 16
) (
  input  logic                      i_core_clk,
  input  logic                      i_rx_rst,
  input  logic                      i_Combine_process_request,
  input  logic [E_W-1:0]            i_Current_Combine_E01_Size,
  input  logic [ADDR_W-1:0]         i_Current_Combine_Ncb_Size,
  input  logic [ADDR_W-1:0]         i_Current_K0,
  output logic [ADDR_W-1:0]         o_Input_Buffer_Offset_Address,
  output logic                      o_Input_Buffer_RDM_Data_Enable,
  input  logic [LANES*LLR_W-1:0]    i_Input_Buffer_RDM_Data,
  input  logic                      i_RDM_Data_Request,
  output logic                      o_Rdm_Valid,
  output logic [ADDR_W-1:0]         o_Rdm_Addr,
  output logic [LANES-1:0]          o_Rdm_Lane_Mask,
  output logic [LANES*LLR_W-1:0]    o_Rdm_Data,
  output logic                      o_Rdm_Accumulate,
  output logic                      o_Rdm_Busy,
  output logic                      o_Rdm_Done,
  output logic                      o_Cfg_Error
);

  localparam int NW     = $clog2(LANES) + 1;
  localparam int DW     = LANES * LLR_W;
  localparam int PASS_W = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_EMIT, S_EMIT_WRAP, S_DONE
  } state_t;

  state_t              state;
  logic [E_W-1:0]      rem_q;
  logic [ADDR_W-1:0]   ncb_q;
  logic [ADDR_W-1:0]   pos_q;
  logic [ADDR_W-1:0]   word_q;
  logic [PASS_W-1:0]   pass_q;
  logic [DW-1:0]       data_q;
  logic [NW-1:0]       n_q;
  logic [NW-1:0]       s_q;
  logic                split_q;

  logic [NW-1:0]       n_c;
  logic [ADDR_W-1:0]   s_c;
  logic                split_c;
  logic [ADDR_W-1:0]   pos_sum;
  logic [ADDR_W-1:0]   pos_after;
  logic [PASS_W-1:0]   pass_after;
  logic [E_W-1:0]      rem_after;

  // Low k lanes set, contiguous from lane 0
  function automatic logic [LANES-1:0] low_mask(input logic [NW-1:0] k);
    logic [LANES-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) m[i] = (i < int'(k));
    return m;
  endfunction

  // Zero every lane whose mask bit is clear
  function automatic logic [DW-1:0] apply_mask(input logic [DW-1:0] d, input logic [LANES-1:0] m);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) r[i*LLR_W +: LLR_W] = m[i] ? d[i*LLR_W +: LLR_W] : '0;
    return r;
  endfunction

  // Per-word sizing and end-of-beat position/pass bookkeeping
  always_comb begin
    n_c       = (rem_q >= E_W'(LANES)) ? NW'(LANES) : rem_q[NW-1:0];
    s_c       = ncb_q - pos_q;
    split_c   = (ADDR_W'(n_c) > s_c);
    pos_sum   = pos_q + ADDR_W'(n_q);
    rem_after = rem_q - E_W'(n_q);
    pass_after = pass_q;
    if (state == S_EMIT_WRAP) begin
      pos_after = ADDR_W'(n_q - s_q);
      if (pass_q != '1) pass_after = pass_q + 1'b1;
    end else if (pos_sum == ncb_q) begin
      pos_after = '0;
      if (pass_q != '1) pass_after = pass_q + 1'b1;
    end else begin
      pos_after = pos_sum;
    end
  end

  // Job sequencer with registered outputs
  always_ff @(posedge i_core_clk) begin
    if (i_rx_rst) begin
      state   <= S_IDLE;
      rem_q   <= '0;
      ncb_q   <= '0;
      pos_q   <= '0;
      word_q  <= '0;
      pass_q  <= '0;
      data_q  <= '0;
      n_q     <= '0;
      s_q     <= '0;
      split_q <= 1'b0;
      o_Input_Buffer_Offset_Address  <= '0;
      o_Input_Buffer_RDM_Data_Enable <= 1'b0;
      o_Rdm_Valid      <= 1'b0;
      o_Rdm_Addr       <= '0;
      o_Rdm_Lane_Mask  <= '0;
      o_Rdm_Data       <= '0;
      o_Rdm_Accumulate <= 1'b0;
      o_Rdm_Busy       <= 1'b0;
      o_Rdm_Done       <= 1'b0;
      o_Cfg_Error      <= 1'b0;
    end else begin
      o_Rdm_Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_Combine_process_request) begin
            rem_q       <= i_Current_Combine_E01_Size;
            ncb_q       <= i_Current_Combine_Ncb_Size;
            pos_q       <= i_Current_K0;
            word_q      <= '0;
            pass_q      <= '0;
            o_Cfg_Error <= 1'b0;
            o_Rdm_Busy  <= 1'b1;
            if (i_Current_Combine_E01_Size == '0) begin
              state      <= S_DONE;
              o_Rdm_Done <= 1'b1;
            end else if (i_Current_Combine_Ncb_Size < ADDR_W'(LANES) ||
                         i_Current_K0 >= i_Current_Combine_Ncb_Size) begin
              o_Cfg_Error <= 1'b1;
              state       <= S_DONE;
              o_Rdm_Done  <= 1'b1;
            end else begin
              state <= S_FETCH;
              o_Input_Buffer_RDM_Data_Enable <= 1'b1;
              o_Input_Buffer_Offset_Address  <= '0;
            end
          end
        end
        S_FETCH: begin
          o_Input_Buffer_RDM_Data_Enable <= 1'b0;
          o_Input_Buffer_Offset_Address  <= '0;
          state <= S_LATCH;
        end
        S_LATCH: begin
          data_q  <= i_Input_Buffer_RDM_Data;
          n_q     <= n_c;
          s_q     <= s_c[NW-1:0];
          split_q <= split_c;
          o_Rdm_Valid      <= 1'b1;
          o_Rdm_Addr       <= pos_q;
          o_Rdm_Accumulate <= (pass_q != '0);
          o_Rdm_Lane_Mask  <= split_c ? low_mask(s_c[NW-1:0]) : low_mask(n_c);
          o_Rdm_Data       <= apply_mask(i_Input_Buffer_RDM_Data,
                                         split_c ? low_mask(s_c[NW-1:0]) : low_mask(n_c));
          state <= S_EMIT;
        end
        S_EMIT, S_EMIT_WRAP: begin
          if (i_RDM_Data_Request) begin
            if (state == S_EMIT && split_q) begin
              // Tail lanes of a word that crosses Ncb restart at position 0
              o_Rdm_Addr       <= '0;
              o_Rdm_Accumulate <= 1'b1;
              o_Rdm_Lane_Mask  <= low_mask(n_q - s_q);
              o_Rdm_Data       <= apply_mask(data_q >> (int'(s_q) * LLR_W), low_mask(n_q - s_q));
              state <= S_EMIT_WRAP;
            end else begin
              pos_q  <= pos_after;
              pass_q <= pass_after;
              rem_q  <= rem_after;
              word_q <= word_q + 1'b1;
              o_Rdm_Valid      <= 1'b0;
              o_Rdm_Addr       <= '0;
              o_Rdm_Lane_Mask  <= '0;
              o_Rdm_Data       <= '0;
              o_Rdm_Accumulate <= 1'b0;
              if (rem_after == '0) begin
                state      <= S_DONE;
                o_Rdm_Done <= 1'b1;
              end else begin
                state <= S_FETCH;
                o_Input_Buffer_RDM_Data_Enable <= 1'b1;
                o_Input_Buffer_Offset_Address  <= word_q + 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          o_Rdm_Busy <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_rdm_lanes.sv
// tb/tb_fsm_rdm_lanes.sv - scoreboard bench for fsm_rdm_lanes
module tb_fsm_rdm_lanes;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [13:0] e_size = '0;
  logic [15:0] ncb = '0;
  logic [15:0] k0 = '0;
  logic [15:0] buf_addr;
  logic        buf_en;
  logic [95:0] buf_data = '0;
  logic        ready = 1'b1;
  logic        valid;
  logic [15:0] addr;
  logic [15:0] mask;
  logic [95:0] data;
  logic        acc;
  logic        busy;
  logic        done;
  logic        cfg_err;

  fsm_rdm_lanes dut (
    .i_core_clk(clk),
    .i_rx_rst(rst),
    .i_Combine_process_request(req),
    .i_Current_Combine_E01_Size(e_size),
    .i_Current_Combine_Ncb_Size(ncb),
    .i_Current_K0(k0),
    .o_Input_Buffer_Offset_Address(buf_addr),
    .o_Input_Buffer_RDM_Data_Enable(buf_en),
    .i_Input_Buffer_RDM_Data(buf_data),
    .i_RDM_Data_Request(ready),
    .o_Rdm_Valid(valid),
    .o_Rdm_Addr(addr),
    .o_Rdm_Lane_Mask(mask),
    .o_Rdm_Data(data),
    .o_Rdm_Accumulate(acc),
    .o_Rdm_Busy(busy),
    .o_Rdm_Done(done),
    .o_Cfg_Error(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] mask;
    logic [95:0] data;
    logic        acc;
  } beat_t;

  beat_t exp_q[$];

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int reads = 0, rd_next = 0, bad_reads = 0, overlap = 0, unstable = 0;
  int done_cnt = 0, done_cyc = 0, beats = 0;
  bit chk_en = 1'b1;
  bit bp_mode = 1'b0;

  function automatic logic [5:0] llr(input int g);
    int v;
    v = (g * 7 + 3) & 63;
    return v[5:0];
  endfunction

  function automatic logic [95:0] mkword(input int w);
    logic [95:0] r;
    for (int l = 0; l < 16; l++) r[l*6 +: 6] = llr(w * 16 + l);
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    tests++;
    if (act !== expv) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push(input int a, input logic [15:0] m, input logic ac, input int eidx);
    beat_t b;
    b.addr = a[15:0];
    b.mask = m;
    b.acc  = ac;
    b.data = '0;
    for (int i = 0; i < 16; i++) if (m[i]) b.data[i*6 +: 6] = llr(eidx + i);
    exp_q.push_back(b);
  endtask

  task automatic push_s1();
    for (int w = 0; w < 6; w++) push(w * 16, 16'hFFFF, 1'b0, w * 16);
    push(96, 16'h3FFF, 1'b0, 96);
    push(0,  16'h0003, 1'b1, 110);
    push(2,  16'hFFFF, 1'b1, 112);
    push(18, 16'h0001, 1'b1, 128);
  endtask

  // Input buffer: one cycle read latency
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (buf_en) buf_data <= mkword(int'(buf_addr));
  end

  // Downstream ready: constant or random back-pressure
  initial forever begin
    @(posedge clk);
    #1;
    ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: reads, done pulses, hold stability and beat scoreboard
  initial begin
    logic        held;
    logic [129:0] held_val;
    beat_t b;
    held = 1'b0;
    held_val = '0;
    forever begin
      @(negedge clk);
      if (chk_en && !rst) begin
        if (buf_en) begin
          reads++;
          if (int'(buf_addr) != rd_next) bad_reads++;
          rd_next++;
          if (valid) overlap++;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (held && {valid, addr, mask, data, acc} != held_val) unstable++;
        held = valid && !ready;
        held_val = {valid, addr, mask, data, acc};
        if (valid && ready) begin
          beats++;
          if (exp_q.size() == 0) begin
            chk("beat_extra", 1, 0);
          end else begin
            b = exp_q.pop_front();
            chk($sformatf("beat%0d_addr", beats), addr, b.addr);
            chk($sformatf("beat%0d_mask", beats), mask, b.mask);
            chk($sformatf("beat%0d_data", beats), data, b.data);
            chk($sformatf("beat%0d_acc", beats), acc, b.acc);
          end
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  int start_cyc = 0;

  task automatic run_job(input string tag, input int e, input int n, input int k,
                         input int exp_reads, input logic exp_cfg);
    int w;
    reads = 0; rd_next = 0; bad_reads = 0; overlap = 0; unstable = 0;
    done_cnt = 0; beats = 0;
    @(posedge clk);
    #1;
    e_size = e[13:0];
    ncb = n[15:0];
    k0 = k[15:0];
    req = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    req = 1'b0;
    w = 0;
    while (done_cnt == 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (done_cnt == 0) chk({tag, "_timeout"}, 0, 1);
    repeat (3) @(negedge clk);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_reads"}, reads, exp_reads);
    chk({tag, "_read_addr_errs"}, bad_reads, 0);
    chk({tag, "_read_while_pending"}, overlap, 0);
    chk({tag, "_unstable_hold"}, unstable, 0);
    chk({tag, "_missing_beats"}, exp_q.size(), 0);
    chk({tag, "_cfg_error"}, cfg_err, exp_cfg);
    chk({tag, "_busy_after"}, busy, 0);
    exp_q.delete();
  endtask

  initial begin
    int vcount;
    int w;
    int dcount;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {valid, addr, mask, data, acc, busy, done, cfg_err, buf_en, buf_addr}, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    push_s1();
    run_job("s1", 129, 110, 0, 9, 1'b0);

    push(100, 16'h03FF, 1'b0, 0);
    push(0,   16'h003F, 1'b1, 10);
    push(6,   16'hFFFF, 1'b1, 16);
    run_job("s2_k0", 32, 110, 100, 2, 1'b0);

    bp_mode = 1'b1;
    push_s1();
    run_job("s1_bp", 129, 110, 0, 9, 1'b0);
    bp_mode = 1'b0;

    run_job("cfg_ncb8", 32, 8, 0, 0, 1'b1);
    run_job("cfg_k0", 32, 110, 110, 0, 1'b1);

    run_job("e_zero", 0, 110, 0, 0, 1'b0);
    chk("e_zero_done_latency_ok", ((done_cyc - start_cyc) >= 1 && (done_cyc - start_cyc) <= 2), 1);

    // Abort a job mid-stream with reset during the third beat
    chk_en = 1'b0;
    @(posedge clk);
    #1;
    e_size = 14'd129;
    ncb = 16'd110;
    k0 = 16'd0;
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    vcount = 0;
    w = 0;
    while (vcount < 3 && w < 500) begin
      @(negedge clk);
      w++;
      if (valid) vcount++;
    end
    chk("rst_reached_beat3", vcount, 3);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_outputs", {valid, addr, mask, data, acc, busy, done, cfg_err, buf_en, buf_addr}, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    dcount = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("rst_mid_no_done", dcount, 0);
    chk("rst_mid_idle_busy", busy, 0);
    chk_en = 1'b1;

    push_s1();
    run_job("s1_after_rst", 129, 110, 0, 9, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
